// File: rtl/temp_sampler.sv
// temp_sampler: front end of the temperature monitor.
// Synchronizes the load pushbutton, optionally debounces it, validates the BCD switch
// digits and captures one reading per press, with a one-cycle en strobe per capture.
// Optional debounce filter: define TEMP_SAMPLER_DEBOUNCE_EN to compile it in.
module temp_sampler #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] sw_ones,
  input  logic [3:0] sw_tens,
  input  logic [3:0] sw_huns,
  input  logic       sw_sign,
  output logic [3:0] temp_value_ones,
  output logic [3:0] temp_value_tens,
  output logic [3:0] temp_value_huns,
  output logic       temp_value_sign,
  output logic [3:0] temp_value_ones_old,
  output logic [3:0] temp_value_tens_old,
  output logic [3:0] temp_value_huns_old,
  output logic       en,
  output logic       error,
  output logic [7:0] sample_count
);

  typedef enum logic {StIdle, StHold} state_e;

  logic load_meta_q, load_s_q;
  logic load_d;

  // Two-flop synchronizer for the asynchronous pushbutton
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_meta_q <= 1'b0;
      load_s_q    <= 1'b0;
    end else begin
      load_meta_q <= load;
      load_s_q    <= load_meta_q;
    end
  end

`ifdef TEMP_SAMPLER_DEBOUNCE_EN
  logic                 load_d_q, load_d_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Level only follows load_s after it has disagreed for DEBOUNCE_CYCLES edges in a row
  always_comb begin
    load_d_d = load_d_q;
    cnt_d    = '0;
    if (load_s_q != load_d_q) begin
      if (cnt_q == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
        load_d_d = ~load_d_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_d_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      load_d_q <= load_d_d;
      cnt_q    <= cnt_d;
    end
  end

  assign load_d = load_d_q;
`else
  // Without the filter the synchronized level is used as is; the parameters have no effect.
  if (DEBOUNCE_CYCLES == 0 && CNT_WIDTH == 0) begin : g_params_unused
  end
  assign load_d = load_s_q;
`endif

  state_e     state_q, state_d;
  logic [3:0] ones_q, ones_d, tens_q, tens_d, huns_q, huns_d;
  logic [3:0] ones_old_q, ones_old_d, tens_old_q, tens_old_d, huns_old_q, huns_old_d;
  logic       sign_q, sign_d;
  logic       en_q, en_d;
  logic       error_q, error_d;
  logic [7:0] count_q, count_d;
  logic       first_q, first_d;
  logic       digits_ok;

  assign digits_ok = (sw_ones <= 4'd9) && (sw_tens <= 4'd9) && (sw_huns <= 4'd9);

  // Capture FSM: one attempt on entry to HOLD, then wait for the button to be released
  always_comb begin
    state_d    = state_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    huns_d     = huns_q;
    sign_d     = sign_q;
    ones_old_d = ones_old_q;
    tens_old_d = tens_old_q;
    huns_old_d = huns_old_q;
    en_d       = 1'b0;
    error_d    = error_q;
    count_d    = count_q;
    first_d    = first_q;
    case (state_q)
      StIdle: begin
        if (load_d) begin
          state_d = StHold;
          if (digits_ok) begin
            // First capture seeds old with the new value so the first delta is zero
            ones_old_d = first_q ? sw_ones : ones_q;
            tens_old_d = first_q ? sw_tens : tens_q;
            huns_old_d = first_q ? sw_huns : huns_q;
            ones_d     = sw_ones;
            tens_d     = sw_tens;
            huns_d     = sw_huns;
            sign_d     = sw_sign;
            en_d       = 1'b1;
            error_d    = 1'b0;
            count_d    = count_q + 8'd1;
            first_d    = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (!load_d) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      huns_q     <= 4'd0;
      sign_q     <= 1'b0;
      ones_old_q <= 4'd0;
      tens_old_q <= 4'd0;
      huns_old_q <= 4'd0;
      en_q       <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= 8'd0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      huns_q     <= huns_d;
      sign_q     <= sign_d;
      ones_old_q <= ones_old_d;
      tens_old_q <= tens_old_d;
      huns_old_q <= huns_old_d;
      en_q       <= en_d;
      error_q    <= error_d;
      count_q    <= count_d;
      first_q    <= first_d;
    end
  end

  assign temp_value_ones     = ones_q;
  assign temp_value_tens     = tens_q;
  assign temp_value_huns     = huns_q;
  assign temp_value_sign     = sign_q;
  assign temp_value_ones_old = ones_old_q;
  assign temp_value_tens_old = tens_old_q;
  assign temp_value_huns_old = huns_old_q;
  assign en                  = en_q;
  assign error               = error_q;
  assign sample_count        = count_q;

endmodule

// File: tb/tb_temp_sampler.sv
// Scoreboard bench for temp_sampler: stimulus pushes expected captures, a monitor pops
// and compares them whenever en is seen.
module tb_temp_sampler;

`ifdef TEMP_SAMPLER_DEBOUNCE_EN
  localparam int Deb = 8;
`else
  localparam int Deb = 0;
`endif
  // Cycles from driving load (at a negedge) to the negedge where en is seen
  localparam int Lat  = 3 + Deb;
  localparam int Hold = Lat + 2;

  logic       clk = 1'b0;
  logic       rst, load, sw_sign;
  logic [3:0] sw_ones, sw_tens, sw_huns;
  logic [3:0] temp_value_ones, temp_value_tens, temp_value_huns;
  logic       temp_value_sign;
  logic [3:0] temp_value_ones_old, temp_value_tens_old, temp_value_huns_old;
  logic       en, error;
  logic [7:0] sample_count;

  temp_sampler #(
    .DEBOUNCE_CYCLES(8),
    .CNT_WIDTH      (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .load               (load),
    .sw_ones            (sw_ones),
    .sw_tens            (sw_tens),
    .sw_huns            (sw_huns),
    .sw_sign            (sw_sign),
    .temp_value_ones    (temp_value_ones),
    .temp_value_tens    (temp_value_tens),
    .temp_value_huns    (temp_value_huns),
    .temp_value_sign    (temp_value_sign),
    .temp_value_ones_old(temp_value_ones_old),
    .temp_value_tens_old(temp_value_tens_old),
    .temp_value_huns_old(temp_value_huns_old),
    .en                 (en),
    .error              (error),
    .sample_count       (sample_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [32:0] v;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   en_seen = 0;
  logic prev_en = 1'b0;

  // Reference model state
  logic [3:0] m_h, m_t, m_o, m_oh, m_ot, m_oo;
  logic       m_s, m_err, m_first;
  logic [7:0] m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [32:0] dut_vec();
    return {temp_value_huns, temp_value_tens, temp_value_ones, temp_value_sign,
            temp_value_huns_old, temp_value_tens_old, temp_value_ones_old, sample_count};
  endfunction

  function automatic logic [32:0] model_vec();
    return {m_h, m_t, m_o, m_s, m_oh, m_ot, m_oo, m_cnt};
  endfunction

  task automatic model_reset();
    {m_h, m_t, m_o, m_s, m_oh, m_ot, m_oo, m_cnt} = '0;
    m_err   = 1'b0;
    m_first = 1'b1;
  endtask

  // Apply one capture attempt to the model; queue the expected response if valid
  task automatic model_capture(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                               input logic s, input int c);
    exp_t e;
    if (h > 4'd9 || t > 4'd9 || o > 4'd9) begin
      m_err = 1'b1;
    end else begin
      if (m_first) {m_oh, m_ot, m_oo} = {h, t, o};
      else         {m_oh, m_ot, m_oo} = {m_h, m_t, m_o};
      {m_h, m_t, m_o, m_s} = {h, t, o, s};
      m_cnt   = m_cnt + 8'd1;
      m_err   = 1'b0;
      m_first = 1'b0;
      e.v   = model_vec();
      e.cyc = c + Lat;
      q.push_back(e);
    end
  endtask

  // Monitor: every en pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (en) begin
      en_seen++;
      if (prev_en) check("en_back_to_back", 64'(prev_en & en), 64'd0);
      if (q.size() == 0) begin
        check("unexpected_en", 64'(q.size()), 64'd1);
      end else begin
        e = q.pop_front();
        check("capture_values", 64'(dut_vec()), 64'(e.v));
        check("en_timing", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_en = en;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                       input logic s, input int hold);
    int   en_before;
    logic valid;
    valid = (h <= 4'd9) && (t <= 4'd9) && (o <= 4'd9);
    {sw_huns, sw_tens, sw_ones, sw_sign} = {h, t, o, s};
    cycles(3);
    en_before = en_seen;
    load = 1'b1;
    model_capture(h, t, o, s, cyc);
    cycles(hold);
    load = 1'b0;
    cycles(Lat + 4);
    check("en_pulses", 64'(en_seen - en_before), 64'(valid));
    check("sb_drained", 64'(q.size()), 64'd0);
    check("error_flag", 64'(error), 64'(m_err));
    check("held_values", 64'(dut_vec()), 64'(model_vec()));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_before;
    rst = 1'b1;
    load = 1'b0;
    {sw_huns, sw_tens, sw_ones, sw_sign} = '0;
    model_reset();
    cycles(3);
    check("reset_values", 64'(dut_vec()), 64'd0);
    check("reset_en_err", 64'({en, error}), 64'd0);
    rst = 1'b0;
    cycles(3);

    press(4'd2, 4'd3, 4'd5, 1'b0, Hold);           // 235: old = current
    press(4'd4, 4'd7, 4'd1, 1'b1, Hold);           // 471: old = 235
    press(4'd4, 4'hB, 4'd1, 1'b0, Hold);           // invalid tens digit
    press(4'd5, 4'd0, 4'd0, 1'b0, Hold);           // 500 clears error
    press(4'd9, 4'hA, 4'hF, 1'b1, Hold);           // invalid again
    press(4'd0, 4'd0, 4'd9, 1'b1, 1000);           // long hold, one capture
`ifdef TEMP_SAMPLER_DEBOUNCE_EN
    press(4'd1, 4'd1, 4'd1, 1'b0, 20);             // 20-cycle press

    // 5-cycle glitch must be filtered out
    en_before = en_seen;
    load = 1'b1;
    cycles(5);
    load = 1'b0;
    cycles(30);
    check("glitch_no_en", 64'(en_seen - en_before), 64'd0);
    check("glitch_values", 64'(dut_vec()), 64'(model_vec()));
`endif

    // 256 valid presses walk the counter through its wrap
    for (int i = 0; i < 256; i++) begin
      press(4'(i % 10), 4'((i / 10) % 10), 4'((i * 7) % 10), i[0], Hold);
    end

    // Reset while the FSM is in HOLD with 471 stored
    {sw_huns, sw_tens, sw_ones, sw_sign} = {4'd4, 4'd7, 4'd1, 1'b0};
    cycles(3);
    load = 1'b1;
    model_capture(4'd4, 4'd7, 4'd1, 1'b0, cyc);
    cycles(Lat + 2);
    check("pre_reset_471", 64'(dut_vec()), 64'(model_vec()));
    load = 1'b0;
    rst = 1'b1;
    #1;
    check("async_reset_values", 64'(dut_vec()), 64'd0);
    check("async_reset_en_err", 64'({en, error}), 64'd0);
    model_reset();
    cycles(3);
    rst = 1'b0;
    cycles(3);
    press(4'd1, 4'd2, 4'd3, 1'b0, Hold);           // old = current = 123, count = 1

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
